// File: rtl/area_bin_pkg.sv
// Shared constants and helpers for the KxK local-mean binarizer.
// The reciprocals are 2^16/9 and 2^16/25, rounded up just enough that flat fields map back to themselves.
package area_bin_pkg;

   localparam int RECIP_3     = 7282;
   localparam int RECIP_5     = 2622;
   localparam int RECIP_SHIFT = 16;
   localparam int LAT         = 6;

   function automatic int sum_width(input int dw, input int k);
      return dw + $clog2(k * k);
   endfunction

   function automatic int saturate(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/area_bin_kxk_if.sv
// Raster in/out and frame-latched config bundle for area_bin_kxk.
// The slave modport is the binarizer side; the master modport is the upstream/bench side.
interface area_bin_kxk_if #(
   parameter int DW   = 8,
   parameter int OFFW = 8
);
   logic                   pix_vs;
   logic                   pix_de;
   logic [DW-1:0]          pix_data;
   logic signed [OFFW-1:0] cfg_offset;
   logic                   cfg_invert;
   logic                   bin_vs;
   logic                   bin_de;
   logic                   bin_data;

   modport master (
      output pix_vs, pix_de, pix_data, cfg_offset, cfg_invert,
      input  bin_vs, bin_de, bin_data
   );

   modport slave (
      input  pix_vs, pix_de, pix_data, cfg_offset, cfg_invert,
      output bin_vs, bin_de, bin_data
   );
endinterface

// File: rtl/area_bin_linebuf.sv
// K-1 cascaded line RAMs feeding a KxK window shift register; row 0 / column 0 are the newest.
// The RAMs are read and written at the same column, so each line moves one RAM down per pass.
module area_bin_linebuf #(
   parameter int DW    = 8,
   parameter int K     = 3,
   parameter int IMG_W = 1280,
   parameter int AW    = $clog2(IMG_W)
) (
   input  logic              video_clk,
   input  logic              rst_n,
   input  logic              de_i,
   input  logic [DW-1:0]     pix_i,
   input  logic [AW-1:0]     addr_i,
   output logic [K*K*DW-1:0] win_o
);
   logic [DW-1:0] mem_q [K-1][IMG_W];
   logic [DW-1:0] col_c [K];
   logic [DW-1:0] win_q [K][K];

   always_comb begin
      col_c[0] = pix_i;
      for (int i = 1; i < K; i++) col_c[i] = mem_q[i-1][addr_i];
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge video_clk) begin
      if (de_i) begin
         for (int i = 0; i < K - 1; i++) mem_q[i][addr_i] <= col_c[i];
      end
   end

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) win_q[i][j] <= '0;
      end else if (de_i) begin
         for (int i = 0; i < K; i++) begin
            win_q[i][0] <= col_c[i];
            for (int j = 1; j < K; j++) win_q[i][j] <= win_q[i][j-1];
         end
      end
   end

   always_comb begin
      win_o = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) win_o[(i*K+j)*DW +: DW] = win_q[i][j];
   end
endmodule

// File: rtl/area_bin_kxk.sv
// Local-mean adaptive binarizer: centre >= (KxK mean - offset), optionally inverted, fixed 6-clock latency.
// Define AREA_BIN_BORDER_EN to force incomplete-window pixels to background (1 ^ invert).
module area_bin_kxk
   import area_bin_pkg::*;
#(
   parameter int DW    = 8,
   parameter int K     = 3,
   parameter int IMG_W = 1280,
   parameter int OFFW  = 8
) (
   input logic           video_clk,
   input logic           rst_n,
   area_bin_kxk_if.slave bus
);
   localparam int SW = sum_width(DW, K);
   localparam int AW = $clog2(IMG_W);
   localparam int RW = 16;
   localparam int CI = (K - 1) / 2;
   localparam int TW = DW + 2;
   localparam int PW = SW + RECIP_SHIFT;
   localparam logic [RECIP_SHIFT-1:0] RECIP_C = RECIP_SHIFT'((K == 3) ? RECIP_3 : RECIP_5);

   if (K != 3 && K != 5) begin : g_bad_k
      $error("area_bin_kxk: K must be 3 or 5");
   end

   logic                   vs_q, de_q, armed_q;
   logic                   vs_rise, de_fall;
   logic [AW-1:0]          col_q, col_d;
   logic [RW-1:0]          row_q, row_d;
   logic signed [OFFW-1:0] offs_q;
   logic                   inv_q;
   logic [K*K*DW-1:0]      win;
   logic [SW-1:0]          rsum_q [K];
   logic [SW-1:0]          rsum_d [K];
   logic [SW-1:0]          total_q, total_d;
   logic [DW-1:0]          mean_q, mean_d;
   logic signed [TW-1:0]   diff;
   logic [DW-1:0]          thr_q, thr_d;
   logic [DW-1:0]          ctr_q [4];
   logic [LAT-1:0]         de_dl_q, vs_dl_q;
   logic                   bin_q, bin_d;

   assign vs_rise = bus.pix_vs & ~vs_q;
   assign de_fall = de_q & ~bus.pix_de;

   // Rows only count once a frame start has been seen, so a mid-frame reset yields border-only pixels.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (vs_rise || !bus.pix_de) col_d = '0;
      else if (col_q != AW'(IMG_W - 1)) col_d = col_q + 1'b1;
      if (vs_rise) row_d = '0;
      else if (de_fall && armed_q && row_q != '1) row_d = row_q + 1'b1;
   end

   area_bin_linebuf #(.DW(DW), .K(K), .IMG_W(IMG_W), .AW(AW)) u_linebuf (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .de_i      (bus.pix_de),
      .pix_i     (bus.pix_data),
      .addr_i    (col_q),
      .win_o     (win)
   );

`ifdef AREA_BIN_BORDER_EN
   logic [LAT-2:0] bord_q;

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) bord_q <= '0;
      else bord_q <= {bord_q[LAT-3:0], (row_q < RW'(K - 1)) || (col_q < AW'(K - 1))};
   end
`endif

   always_comb begin
      total_d = '0;
      for (int i = 0; i < K; i++) begin
         rsum_d[i] = '0;
         for (int j = 0; j < K; j++) rsum_d[i] = rsum_d[i] + SW'(win[(i*K+j)*DW +: DW]);
         total_d = total_d + rsum_q[i];
      end
      mean_d = DW'((PW'(total_q) * PW'(RECIP_C)) >> RECIP_SHIFT);
      diff   = $signed(TW'(mean_q)) - TW'(offs_q);
      thr_d  = DW'(saturate(int'(diff), (1 << DW) - 1));
      bin_d  = 1'b0;
      if (de_dl_q[LAT-2]) begin
         bin_d = (ctr_q[3] >= thr_q) ^ inv_q;
`ifdef AREA_BIN_BORDER_EN
         if (bord_q[LAT-2]) bin_d = ~inv_q;
`endif
      end
   end

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= 1'b0;
         de_q    <= 1'b0;
         armed_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         offs_q  <= '0;
         inv_q   <= 1'b0;
         for (int i = 0; i < K; i++) rsum_q[i] <= '0;
         total_q <= '0;
         mean_q  <= '0;
         thr_q   <= '0;
         for (int i = 0; i < 4; i++) ctr_q[i] <= '0;
         de_dl_q <= '0;
         vs_dl_q <= '0;
         bin_q   <= 1'b0;
      end else begin
         vs_q  <= bus.pix_vs;
         de_q  <= bus.pix_de;
         col_q <= col_d;
         row_q <= row_d;
         if (vs_rise) begin
            armed_q <= 1'b1;
            offs_q  <= bus.cfg_offset;
            inv_q   <= bus.cfg_invert;
         end
         for (int i = 0; i < K; i++) rsum_q[i] <= rsum_d[i];
         total_q  <= total_d;
         mean_q   <= mean_d;
         thr_q    <= thr_d;
         ctr_q[0] <= win[(CI*K+CI)*DW +: DW];
         for (int i = 1; i < 4; i++) ctr_q[i] <= ctr_q[i-1];
         de_dl_q  <= {de_dl_q[LAT-2:0], bus.pix_de};
         vs_dl_q  <= {vs_dl_q[LAT-2:0], bus.pix_vs};
         bin_q    <= bin_d;
      end
   end

   assign bus.bin_vs   = vs_dl_q[LAT-1];
   assign bus.bin_de   = de_dl_q[LAT-1];
   assign bus.bin_data = bin_q;
endmodule

// File: tb/tb_area_bin_kxk.sv
// Directed bench for area_bin_kxk: K=3 and K=5 instances share one 10x8 raster stream.
// Output pixels are captured by raster position and compared against hand-computed results.
module tb_area_bin_kxk;
   localparam int W  = 10;
   localparam int H  = 8;
   localparam int IW = 16;

   logic video_clk = 1'b0;
   logic rst_n     = 1'b0;
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   img [H][W];

   logic [H*W-1:0] obs3 = '0, got3 = '0, obs5 = '0, got5 = '0;
   int   orow3 = 0, ocol3 = 0, orow5 = 0, ocol5 = 0, zv3 = 0, zv5 = 0;
   logic bvs3_p = 1'b0, bde3_p = 1'b0, bvs5_p = 1'b0, bde5_p = 1'b0, pde_p = 1'b0, pvs_p = 1'b0;
   int   in_de_cyc = 0, out_de_cyc = 0, in_vs_cyc = 0, out_vs_cyc = 0;

   always #5 video_clk = ~video_clk;
   always @(posedge video_clk) cyc <= cyc + 1;

   area_bin_kxk_if #(.DW(8), .OFFW(8)) bus3 ();
   area_bin_kxk_if #(.DW(8), .OFFW(8)) bus5 ();

   assign bus5.pix_vs     = bus3.pix_vs;
   assign bus5.pix_de     = bus3.pix_de;
   assign bus5.pix_data   = bus3.pix_data;
   assign bus5.cfg_offset = bus3.cfg_offset;
   assign bus5.cfg_invert = bus3.cfg_invert;

   area_bin_kxk #(.DW(8), .K(3), .IMG_W(IW), .OFFW(8)) dut3 (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .bus       (bus3)
   );

   area_bin_kxk #(.DW(8), .K(5), .IMG_W(IW), .OFFW(8)) dut5 (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .bus       (bus5)
   );

   always @(negedge video_clk) begin
      if (bus3.bin_vs && !bvs3_p) begin
         orow3 <= 0;
         ocol3 <= 0;
         got3  <= '0;
      end else if (bus3.bin_de) begin
         if (orow3 < H && ocol3 < W) begin
            obs3[7'(orow3*W+ocol3)] <= bus3.bin_data;
            got3[7'(orow3*W+ocol3)] <= 1'b1;
         end
         ocol3 <= ocol3 + 1;
      end else if (bde3_p) begin
         orow3 <= orow3 + 1;
         ocol3 <= 0;
      end
      if (!bus3.bin_de && bus3.bin_data !== 1'b0) zv3 <= zv3 + 1;
      bvs3_p <= bus3.bin_vs;
      bde3_p <= bus3.bin_de;
   end

   always @(negedge video_clk) begin
      if (bus5.bin_vs && !bvs5_p) begin
         orow5 <= 0;
         ocol5 <= 0;
         got5  <= '0;
      end else if (bus5.bin_de) begin
         if (orow5 < H && ocol5 < W) begin
            obs5[7'(orow5*W+ocol5)] <= bus5.bin_data;
            got5[7'(orow5*W+ocol5)] <= 1'b1;
         end
         ocol5 <= ocol5 + 1;
      end else if (bde5_p) begin
         orow5 <= orow5 + 1;
         ocol5 <= 0;
      end
      if (!bus5.bin_de && bus5.bin_data !== 1'b0) zv5 <= zv5 + 1;
      bvs5_p <= bus5.bin_vs;
      bde5_p <= bus5.bin_de;
   end

   always @(negedge video_clk) begin
      if (bus3.pix_de && !pde_p) in_de_cyc <= cyc;
      if (bus3.pix_vs && !pvs_p) in_vs_cyc <= cyc;
      if (bus3.bin_de && !bde3_p) out_de_cyc <= cyc;
      if (bus3.bin_vs && !bvs3_p) out_vs_cyc <= cyc;
      pde_p <= bus3.pix_de;
      pvs_p <= bus3.pix_vs;
   end

   function automatic logic px3(input int r, input int c);
      return got3[r*W+c] ? obs3[r*W+c] : 1'bx;
   endfunction

   function automatic logic px5(input int r, input int c);
      return got5[r*W+c] ? obs5[r*W+c] : 1'bx;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge video_clk);
         #1;
      end
   endtask

   task automatic fill_flat(input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic set_cfg(input logic signed [7:0] off, input logic inv);
      bus3.cfg_offset = off;
      bus3.cfg_invert = inv;
   endtask

   task automatic drive_frame(input int chg_row, input logic signed [7:0] chg_off);
      tick(1);
      bus3.pix_vs = 1'b1;
      tick(2);
      bus3.pix_vs = 1'b0;
      tick(3);
      for (int r = 0; r < H; r++) begin
         if (r == chg_row) bus3.cfg_offset = chg_off;
         for (int c = 0; c < W; c++) begin
            bus3.pix_de   = 1'b1;
            bus3.pix_data = 8'(img[r][c]);
            tick(1);
         end
         bus3.pix_de   = 1'b0;
         bus3.pix_data = 8'd0;
         tick(4);
      end
      tick(10);
   endtask

   task automatic test_reset();
      bus3.pix_vs = 1'b0;
      bus3.pix_de = 1'b0;
      bus3.pix_data = 8'd0;
      set_cfg(8'sd0, 1'b0);
      rst_n = 1'b0;
      tick(3);
      checks++;
      if ({bus3.bin_vs, bus3.bin_de, bus3.bin_data} !== 3'b000) begin
         errors++;
         $display("FAIL reset_k3 got=%b exp=000", {bus3.bin_vs, bus3.bin_de, bus3.bin_data});
      end
      checks++;
      if ({bus5.bin_vs, bus5.bin_de, bus5.bin_data} !== 3'b000) begin
         errors++;
         $display("FAIL reset_k5 got=%b exp=000", {bus5.bin_vs, bus5.bin_de, bus5.bin_data});
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_flat();
      set_cfg(8'sd0, 1'b0);
      fill_flat(100);
      drive_frame(-1, 8'sd0);
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++) begin
            checks++;
            if (px3(r, c) !== 1'b1) begin
               errors++;
               $display("FAIL flat_k3 r=%0d c=%0d got=%b exp=1", r, c, px3(r, c));
            end
         end
      for (int r = 4; r < H; r++)
         for (int c = 4; c < W; c++) begin
            checks++;
            if (px5(r, c) !== 1'b1) begin
               errors++;
               $display("FAIL flat_k5 r=%0d c=%0d got=%b exp=1", r, c, px5(r, c));
            end
         end
   endtask

   task automatic test_offset();
      fill_flat(100);
      for (int inv = 0; inv < 2; inv++) begin
         set_cfg(-8'sd5, inv[0]);
         drive_frame(-1, 8'sd0);
         for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
               checks++;
               if (px3(r, c) !== inv[0]) begin
                  errors++;
                  $display("FAIL offset_inv%0d r=%0d c=%0d got=%b exp=%b", inv, r, c, px3(r, c), inv[0]);
               end
            end
      end
   endtask

   task automatic test_spot();
      set_cfg(8'sd0, 1'b0);
      fill_flat(50);
      img[3][4] = 200;
      drive_frame(-1, 8'sd0);
      checks++;
      if (px5(5, 6) !== 1'b1) begin errors++; $display("FAIL spot_k5_centre got=%b exp=1", px5(5, 6)); end
      checks++;
      if (px5(5, 5) !== 1'b0) begin errors++; $display("FAIL spot_k5_left got=%b exp=0", px5(5, 5)); end
      checks++;
      if (px5(4, 6) !== 1'b0) begin errors++; $display("FAIL spot_k5_up got=%b exp=0", px5(4, 6)); end
      checks++;
      if (px5(6, 7) !== 1'b0) begin errors++; $display("FAIL spot_k5_diag got=%b exp=0", px5(6, 7)); end
      checks++;
      if (px5(7, 9) !== 1'b1) begin errors++; $display("FAIL spot_k5_far got=%b exp=1", px5(7, 9)); end
      checks++;
      if (px3(4, 5) !== 1'b1) begin errors++; $display("FAIL spot_k3_centre got=%b exp=1", px3(4, 5)); end
      checks++;
      if (px3(4, 4) !== 1'b0) begin errors++; $display("FAIL spot_k3_left got=%b exp=0", px3(4, 4)); end
   endtask

   task automatic test_saturation();
      set_cfg(-8'sd20, 1'b0);
      fill_flat(250);
      drive_frame(-1, 8'sd0);
      checks++;
      if (px3(4, 5) !== 1'b0) begin errors++; $display("FAIL sat_hi_k3 got=%b exp=0", px3(4, 5)); end
      checks++;
      if (px5(6, 7) !== 1'b0) begin errors++; $display("FAIL sat_hi_k5 got=%b exp=0", px5(6, 7)); end
      set_cfg(8'sd20, 1'b0);
      fill_flat(5);
      drive_frame(-1, 8'sd0);
      checks++;
      if (px3(4, 5) !== 1'b1) begin errors++; $display("FAIL sat_lo_k3 got=%b exp=1", px3(4, 5)); end
      checks++;
      if (px5(6, 7) !== 1'b1) begin errors++; $display("FAIL sat_lo_k5 got=%b exp=1", px5(6, 7)); end
   endtask

   task automatic test_border();
      set_cfg(-8'sd20, 1'b0);
      fill_flat(250);
      drive_frame(-1, 8'sd0);
      checks++;
      if (out_de_cyc - in_de_cyc !== 6) begin
         errors++;
         $display("FAIL lat_de got=%0d exp=6", out_de_cyc - in_de_cyc);
      end
      checks++;
      if (out_vs_cyc - in_vs_cyc !== 6) begin
         errors++;
         $display("FAIL lat_vs got=%0d exp=6", out_vs_cyc - in_vs_cyc);
      end
      checks++;
      if (px3(3, 3) !== 1'b0) begin errors++; $display("FAIL border_interior got=%b exp=0", px3(3, 3)); end
`ifdef AREA_BIN_BORDER_EN
      checks++;
      if (px3(0, 3) !== 1'b1) begin errors++; $display("FAIL border_k3_r0 got=%b exp=1", px3(0, 3)); end
      checks++;
      if (px3(1, 8) !== 1'b1) begin errors++; $display("FAIL border_k3_r1 got=%b exp=1", px3(1, 8)); end
      checks++;
      if (px3(5, 0) !== 1'b1) begin errors++; $display("FAIL border_k3_c0 got=%b exp=1", px3(5, 0)); end
      checks++;
      if (px3(7, 1) !== 1'b1) begin errors++; $display("FAIL border_k3_c1 got=%b exp=1", px3(7, 1)); end
      checks++;
      if (px5(3, 9) !== 1'b1) begin errors++; $display("FAIL border_k5_r3 got=%b exp=1", px5(3, 9)); end
      checks++;
      if (px5(6, 2) !== 1'b1) begin errors++; $display("FAIL border_k5_c2 got=%b exp=1", px5(6, 2)); end
`endif
   endtask

   task automatic test_reset_midframe();
      set_cfg(8'sd0, 1'b0);
      tick(1);
      bus3.pix_vs = 1'b1;
      tick(2);
      bus3.pix_vs = 1'b0;
      tick(3);
      for (int r = 0; r < 2; r++) begin
         bus3.pix_de   = 1'b1;
         bus3.pix_data = 8'd100;
         tick(W);
         bus3.pix_de = 1'b0;
         tick(4);
      end
      bus3.pix_de   = 1'b1;
      bus3.pix_data = 8'd100;
      tick(8);
      checks++;
      if (bus3.bin_de !== 1'b1) begin errors++; $display("FAIL pre_reset_de got=%b exp=1", bus3.bin_de); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus3.bin_vs, bus3.bin_de, bus3.bin_data} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_k3 got=%b exp=000", {bus3.bin_vs, bus3.bin_de, bus3.bin_data});
      end
      tick(3);
      checks++;
      if ({bus5.bin_vs, bus5.bin_de, bus5.bin_data} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_k5 got=%b exp=000", {bus5.bin_vs, bus5.bin_de, bus5.bin_data});
      end
      bus3.pix_de   = 1'b0;
      bus3.pix_data = 8'd0;
      rst_n = 1'b1;
      tick(10);
   endtask

   task automatic test_cfg_midframe();
      set_cfg(8'sd0, 1'b0);
      fill_flat(100);
      drive_frame(3, -8'sd5);
      checks++;
      if (px3(4, 5) !== 1'b1) begin errors++; $display("FAIL cfg_hold_k3_a got=%b exp=1", px3(4, 5)); end
      checks++;
      if (px3(7, 9) !== 1'b1) begin errors++; $display("FAIL cfg_hold_k3_b got=%b exp=1", px3(7, 9)); end
      checks++;
      if (px5(7, 9) !== 1'b1) begin errors++; $display("FAIL cfg_hold_k5 got=%b exp=1", px5(7, 9)); end
      drive_frame(-1, 8'sd0);
      checks++;
      if (px3(4, 5) !== 1'b0) begin errors++; $display("FAIL cfg_next_k3_a got=%b exp=0", px3(4, 5)); end
      checks++;
      if (px3(7, 9) !== 1'b0) begin errors++; $display("FAIL cfg_next_k3_b got=%b exp=0", px3(7, 9)); end
      checks++;
      if (px5(7, 9) !== 1'b0) begin errors++; $display("FAIL cfg_next_k5 got=%b exp=0", px5(7, 9)); end
   endtask

   task automatic test_idle_zero();
      checks++;
      if (zv3 !== 0) begin errors++; $display("FAIL idle_zero_k3 got=%0d exp=0", zv3); end
      checks++;
      if (zv5 !== 0) begin errors++; $display("FAIL idle_zero_k5 got=%0d exp=0", zv5); end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_offset();
      test_spot();
      test_saturation();
      test_border();
      test_reset_midframe();
      test_cfg_midframe();
      test_idle_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
